// File: rtl/neuron_weight_reader_pkg.sv
// neuron_weight_reader_pkg: evaluation states and default widths shared by the weight reader slice
package neuron_weight_reader_pkg;
    localparam int DEF_N_INPUTS = 10;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W = 40;
    typedef enum logic [1:0] {IDLE, FETCH, MAC, DONE} state_t;
endpackage

// File: rtl/neuron_weight_reader_if.sv
// neuron_weight_reader_if: ROM read port, activation stream and result stream of one neuron
interface neuron_weight_reader_if import neuron_weight_reader_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W = DEF_ACC_W
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic x_valid;
    logic [DATA_W-1:0] x_data;
    logic x_ready;
    logic y_valid;
    logic [ACC_W-1:0] y_sum;
    logic y_fire;
    logic y_ready;
    modport master (
        output rom_addr, x_ready, y_valid, y_sum, y_fire,
        input rom_dout, x_valid, x_data, y_ready
    );
    modport slave (
        input rom_addr, x_ready, y_valid, y_sum, y_fire,
        output rom_dout, x_valid, x_data, y_ready
    );
endinterface

// File: rtl/neuron_weight_reader_mac.sv
// neuron_weight_reader_mac: unsigned-weight by signed-activation multiply-accumulate, wrapping
module neuron_weight_reader_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W = 40
) (
    input logic clk,
    input logic rst_n,
    input logic clr,
    input logic en,
    input logic [DATA_W-1:0] w,
    input logic [DATA_W-1:0] x,
    output logic [ACC_W-1:0] acc
);
    logic signed [2*DATA_W:0] prod;
    assign prod = $signed({1'b0, w}) * $signed(x);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) acc <= '0;
        else if (clr) acc <= '0;
        else if (en) acc <= acc + {{(ACC_W-2*DATA_W-1){prod[2*DATA_W]}}, prod};
endmodule

// File: rtl/neuron_weight_reader.sv
// neuron_weight_reader: walks ROM addresses 1..N_INPUTS, pairs each weight with a streamed
// activation, and presents the weighted sum plus a fire bit on a valid/ready output.
module neuron_weight_reader import neuron_weight_reader_pkg::*; #(
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter logic signed [ACC_W-1:0] THRESHOLD = '0
) (
    input logic clk,
    input logic rst_n,
    input logic start,
    output logic busy,
    neuron_weight_reader_if.master bus
);
    state_t state;
    logic w_vld;
    logic hs_x;
    logic [ACC_W-1:0] acc;
    assign bus.x_ready = state == MAC && w_vld;
    assign hs_x = bus.x_valid && bus.x_ready;
    neuron_weight_reader_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk(clk),
        .rst_n(rst_n),
        .clr(state == IDLE && start),
        .en(hs_x),
        .w(bus.rom_dout),
        .x(bus.x_data),
        .acc(acc)
    );
    // w_vld drops for one cycle after each address step to cover the ROM read latency
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            w_vld <= 1'b0;
            busy <= 1'b0;
            bus.rom_addr <= '0;
            bus.y_valid <= 1'b0;
            bus.y_sum <= '0;
            bus.y_fire <= 1'b0;
        end else
            case (state)
                IDLE: if (start) begin
                    bus.rom_addr <= ADDR_W'(1);
                    busy <= 1'b1;
                    w_vld <= 1'b0;
                    state <= FETCH;
                end
                FETCH: begin
                    w_vld <= 1'b1;
                    state <= MAC;
                end
                MAC: if (!w_vld) w_vld <= 1'b1;
                else if (hs_x) begin
                    if (bus.rom_addr == ADDR_W'(N_INPUTS)) state <= DONE;
                    else begin
                        bus.rom_addr <= bus.rom_addr + 1'b1;
                        w_vld <= 1'b0;
                    end
                end
                DONE: if (!bus.y_valid) begin
                    bus.y_sum <= acc;
                    bus.y_fire <= $signed(acc) > THRESHOLD;
                    bus.y_valid <= 1'b1;
                end else if (bus.y_ready) begin
                    bus.y_valid <= 1'b0;
                    busy <= 1'b0;
                    bus.rom_addr <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
endmodule

// File: tb/tb_neuron_weight_reader.sv
// tb_neuron_weight_reader: scoreboard bench with a registered-read weight ROM model
module tb_neuron_weight_reader;
    typedef struct {
        logic [39:0] sum;
        logic fire;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [15:0] wt [0:10] = '{16'd0, 16'd1, 16'd3, 16'd4, 16'd5, 16'd6, 16'd8, 16'd9, 16'd10, 16'd11, 16'd13};
    neuron_weight_reader_if bus ();
    neuron_weight_reader dut (.clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) bus.rom_dout <= (bus.rom_addr <= 16'd10) ? wt[bus.rom_addr[3:0]] : 16'd0;
    function automatic logic signed [15:0] xval(input int mode, input int k);
        case (mode)
            0: return 16'sd1;
            1: return -16'sd1;
            2: return 16'sd0;
            3: return 16'(k);
            default: return 16'sh7FFF;
        endcase
    endfunction
    task automatic feed(input int mode, input bit gaps, input int stop);
        longint e = 0;
        int k = 1;
        int cyc = 0;
        exp_t x;
        for (int i = 1; i <= 10; i++) e += longint'(wt[i]) * longint'(xval(mode, i));
        x.sum = 40'(e);
        x.fire = e > 0;
        if (stop >= 10) sb.push_back(x);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (k <= stop && cyc < 100) begin
            bus.x_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.x_data = xval(mode, k);
            if (!gaps && cyc < 2) begin
                checks++;
                if (bus.x_ready !== (cyc == 1)) begin
                    errors++;
                    $display("FAIL x_ready_latency cyc=%0d: got %b expected %b", cyc, bus.x_ready, cyc == 1);
                end
            end
            if (bus.x_ready) begin
                checks++;
                if (bus.rom_addr !== 16'(k)) begin
                    errors++;
                    $display("FAIL rom_addr k=%0d: got %0d expected %0d", k, bus.rom_addr, k);
                end
            end
            if (bus.x_ready && bus.x_valid) k++;
            @(negedge clk);
            cyc++;
        end
        bus.x_valid = 1'b0;
        if (k <= stop) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: got %0d accepted expected %0d", k - 1, stop);
        end
    endtask
    task automatic collect(input int hold);
        int n = 0;
        exp_t x;
        while (!bus.y_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.y_valid) begin
            errors++;
            $display("FAIL y_valid_timeout: got 0 expected 1");
            return;
        end
        x = sb.pop_front();
        checks++;
        if (bus.y_sum !== x.sum || bus.y_fire !== x.fire) begin
            errors++;
            $display("FAIL result: got sum=%0d fire=%b expected sum=%0d fire=%b",
                $signed(bus.y_sum), bus.y_fire, $signed(x.sum), x.fire);
        end
        for (int i = 0; i < hold; i++) begin
            start = (i == 2);
            @(negedge clk);
            checks++;
            if (bus.y_valid !== 1'b1 || bus.y_sum !== x.sum || bus.y_fire !== x.fire || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold cyc=%0d: got v=%b sum=%0d fire=%b busy=%b expected v=1 sum=%0d fire=%b busy=1",
                    i, bus.y_valid, $signed(bus.y_sum), bus.y_fire, busy, $signed(x.sum), x.fire);
            end
        end
        bus.y_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        bus.y_ready = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.y_valid !== 1'b0 || busy !== 1'b0 || bus.rom_addr !== 16'd0 || bus.y_sum !== x.sum) begin
                errors++;
                $display("FAIL after_handshake cyc=%0d: got v=%b busy=%b addr=%0d sum=%0d expected v=0 busy=0 addr=0 sum=%0d",
                    i, bus.y_valid, busy, bus.rom_addr, $signed(bus.y_sum), $signed(x.sum));
            end
            @(negedge clk);
        end
    endtask
    task automatic test_reset();
        bus.x_valid = 1'b0;
        bus.x_data = '0;
        bus.y_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rom_addr !== 16'd0 || busy !== 1'b0 || bus.x_ready !== 1'b0 || bus.y_valid !== 1'b0 || bus.y_sum !== 40'd0 || bus.y_fire !== 1'b0) begin
            errors++;
            $display("FAIL reset: got addr=%0d busy=%b xr=%b yv=%b sum=%0d fire=%b expected all 0",
                bus.rom_addr, busy, bus.x_ready, bus.y_valid, bus.y_sum, bus.y_fire);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask
    task automatic test_patterns();
        for (int m = 0; m < 3; m++) begin
            feed(m, 1'b0, 10);
            collect(0);
        end
    endtask
    task automatic test_gaps();
        feed(3, 1'b1, 10);
        collect(0);
    endtask
    task automatic test_hold();
        feed(0, 1'b0, 10);
        collect(5);
    endtask
    task automatic test_midreset();
        feed(0, 1'b0, 4);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rom_addr !== 16'd0 || busy !== 1'b0 || bus.x_ready !== 1'b0 || bus.y_valid !== 1'b0 || bus.y_sum !== 40'd0 || bus.y_fire !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got addr=%0d busy=%b xr=%b yv=%b sum=%0d fire=%b expected all 0",
                bus.rom_addr, busy, bus.x_ready, bus.y_valid, bus.y_sum, bus.y_fire);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        feed(0, 1'b0, 10);
        collect(0);
    endtask
    task automatic test_max();
        feed(4, 1'b0, 10);
        collect(0);
    endtask
    initial begin
        test_reset();
        test_patterns();
        test_gaps();
        test_hold();
        test_midreset();
        test_max();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
